// File: rtl/branch_sequencer_pkg.sv
// Shared constants for the branch sequencer and the core ALU: funct3 codes, ALU op
// encodings and sequencer state encodings.
package branch_sequencer_pkg;

  localparam logic [2:0] F3Beq  = 3'b000;
  localparam logic [2:0] F3Bne  = 3'b001;
  localparam logic [2:0] F3Blt  = 3'b100;
  localparam logic [2:0] F3Bge  = 3'b101;
  localparam logic [2:0] F3Bltu = 3'b110;
  localparam logic [2:0] F3Bgeu = 3'b111;

  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluSlt  = 2;
  localparam int unsigned AluSltu = 3;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCmp   = 2'd1,
    StTgt   = 2'd2,
    StRedir = 2'd3
  } seq_state_e;

endpackage

// File: rtl/branch_sequencer_condition.sv
// branch_condition: combinational funct3 decode into an ALU compare op, plus
// taken/illegal evaluation from the ALU result.
module branch_condition
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     alu_out_i,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output logic                taken_o,
  output logic                illegal_o
);

  always_comb begin
    alu_op_o  = ALU_OP_W'(AluSub);
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    unique case (funct3_i)
      F3Beq:  taken_o = ~(|alu_out_i);
      F3Bne:  taken_o = |alu_out_i;
      F3Blt: begin
        alu_op_o = ALU_OP_W'(AluSlt);
        taken_o  = alu_out_i[0];
      end
      F3Bge: begin
        alu_op_o = ALU_OP_W'(AluSlt);
        taken_o  = ~alu_out_i[0];
      end
      F3Bltu: begin
        alu_op_o = ALU_OP_W'(AluSltu);
        taken_o  = alu_out_i[0];
      end
      F3Bgeu: begin
        alu_op_o = ALU_OP_W'(AluSltu);
        taken_o  = ~alu_out_i[0];
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle conditional-branch resolver sharing the core ALU: compare, optional target add,
// then redirect/flush handshake. Optional feature macro: BRANCH_MISALIGN_TRAP_EN.
module branch_sequencer
  import branch_sequencer_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [2:0]          funct3,
  input  logic [XLEN-1:0]     rs1_val,
  input  logic [XLEN-1:0]     rs2_val,
  input  logic [XLEN-1:0]     pc,
  input  logic [XLEN-1:0]     imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_out,
  output logic                redirect_valid,
  input  logic                redirect_ready,
  output logic [XLEN-1:0]     redirect_pc,
  output logic                flush,
  output logic                done,
  output logic                taken,
  output logic                illegal,
  output logic                misalign
);

  seq_state_e      state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d, pc_q, pc_d, imm_q, imm_d;
  logic [XLEN-1:0] target_q, target_d;
  logic            done_q, done_d, taken_q, taken_d, illegal_q, illegal_d;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic            misalign_q, misalign_d;
`endif

  logic [ALU_OP_W-1:0] cmp_op;
  logic                cmp_taken, cmp_illegal;

  branch_condition #(
    .XLEN     (XLEN),
    .ALU_OP_W (ALU_OP_W)
  ) u_cond (
    .funct3_i  (funct3_q),
    .alu_out_i (alu_out),
    .alu_op_o  (cmp_op),
    .taken_o   (cmp_taken),
    .illegal_o (cmp_illegal)
  );

  always_comb begin
    state_d        = state_q;
    funct3_d       = funct3_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    pc_d           = pc_q;
    imm_d          = imm_q;
    target_d       = target_q;
    // Completion flags are single-cycle pulses unless set below.
    done_d         = 1'b0;
    taken_d        = 1'b0;
    illegal_d      = 1'b0;
`ifdef BRANCH_MISALIGN_TRAP_EN
    misalign_d     = 1'b0;
`endif
    ready          = 1'b0;
    alu_op         = ALU_OP_W'(AluAdd);
    alu_a          = '0;
    alu_b          = '0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    case (state_q)
      StIdle: begin
        ready = 1'b1;
        if (start) begin
          funct3_d = funct3;
          rs1_d    = rs1_val;
          rs2_d    = rs2_val;
          pc_d     = pc;
          imm_d    = imm;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        alu_op = cmp_op;
        alu_a  = rs1_q;
        alu_b  = rs2_q;
        if (cmp_illegal) begin
          done_d    = 1'b1;
          illegal_d = 1'b1;
          state_d   = StIdle;
        end else if (cmp_taken) begin
          state_d = StTgt;
        end else begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      StTgt: begin
        alu_a    = pc_q;
        alu_b    = imm_q;
        target_d = alu_out;
        state_d  = StRedir;
`ifdef BRANCH_MISALIGN_TRAP_EN
        if (|alu_out[1:0]) begin
          done_d     = 1'b1;
          taken_d    = 1'b1;
          misalign_d = 1'b1;
          state_d    = StIdle;
        end
`endif
      end
      StRedir: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        if (redirect_ready) begin
          done_d  = 1'b1;
          taken_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      pc_q      <= '0;
      imm_q     <= '0;
      target_q  <= '0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      pc_q      <= pc_d;
      imm_q     <= imm_d;
      target_q  <= target_d;
      done_q    <= done_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef BRANCH_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  assign redirect_pc = target_q;
  assign done        = done_q;
  assign taken       = taken_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer with a behavioural model of the shared ALU.
module tb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1_val = '0, rs2_val = '0, pc = '0, imm = '0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        flush, done, taken, illegal, misalign;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Shared ALU model: ADD=0 SUB=1 SLT=2 SLTU=3.
  always_comb begin
    alu_out = '0;
    case (alu_op)
      4'd0: alu_out = alu_a + alu_b;
      4'd1: alu_out = alu_a - alu_b;
      4'd2: alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'd3: alu_out = {31'b0, alu_a < alu_b};
      default: alu_out = '0;
    endcase
  end

  branch_sequencer #(
    .XLEN     (32),
    .ALU_OP_W (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ready          (ready),
    .funct3         (funct3),
    .rs1_val        (rs1_val),
    .rs2_val        (rs2_val),
    .pc             (pc),
    .imm            (imm),
    .alu_op         (alu_op),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_out        (alu_out),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .done           (done),
    .taken          (taken),
    .illegal        (illegal),
    .misalign       (misalign)
  );

  // Present a branch for one accept edge; returns just after that edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, b, p, i);
    funct3 = f; rs1_val = a; rs2_val = b; pc = p; imm = i;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({ready, redirect_valid, flush, done, taken, illegal, misalign} !== 7'b1000000) begin
      tests_failed++;
      $display("FAIL reset_flags got=%b want=1000000",
               {ready, redirect_valid, flush, done, taken, illegal, misalign});
    end
    tests_run++;
    if ({alu_op, alu_a, alu_b, redirect_pc} !== 100'd0) begin
      tests_failed++;
      $display("FAIL reset_alu op=%0d a=%h b=%h rpc=%h want all 0", alu_op, alu_a, alu_b,
               redirect_pc);
    end
    rst = 1'b0;
  endtask

  task automatic test_beq_taken;
    issue(3'b000, 32'h12345678, 32'h12345678, 32'h100, 32'h20);
    @(negedge clk);  // CMP
    tests_run++;
    if ({alu_op, alu_a, alu_b, ready} !== {4'd1, 32'h12345678, 32'h12345678, 1'b0}) begin
      tests_failed++;
      $display("FAIL beq_cmp op=%0d a=%h b=%h ready=%b want op=1 a=b=12345678 ready=0",
               alu_op, alu_a, alu_b, ready);
    end
    @(negedge clk);  // TGT
    tests_run++;
    if ({alu_op, alu_a, alu_b} !== {4'd0, 32'h100, 32'h20}) begin
      tests_failed++;
      $display("FAIL beq_tgt op=%0d a=%h b=%h want op=0 a=100 b=20", alu_op, alu_a, alu_b);
    end
    @(negedge clk);  // REDIR
    tests_run++;
    if ({redirect_valid, flush, redirect_pc, done} !== {2'b11, 32'h120, 1'b0}) begin
      tests_failed++;
      $display("FAIL beq_redir rv=%b flush=%b rpc=%h done=%b want 1 1 120 0",
               redirect_valid, flush, redirect_pc, done);
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    tests_run++;
    if ({done, taken, illegal, redirect_valid, flush, ready} !== 6'b110001) begin
      tests_failed++;
      $display("FAIL beq_done got=%b want=110001",
               {done, taken, illegal, redirect_valid, flush, ready});
    end
    @(negedge clk);
    tests_run++;
    if ({done, taken} !== 2'b00) begin
      tests_failed++;
      $display("FAIL beq_done_clear done=%b taken=%b want 0 0", done, taken);
    end
  endtask

  task automatic test_bne;
    logic [31:0] b_tab [2];
    logic        t_tab [2];
    b_tab[0] = 32'h5; t_tab[0] = 1'b0;
    b_tab[1] = 32'h6; t_tab[1] = 1'b1;
    redirect_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      issue(3'b001, 32'h5, b_tab[k], 32'h40, 32'h10);
      @(negedge clk);
      tests_run++;
      if ({alu_op, redirect_valid, done} !== {4'd1, 2'b00}) begin
        tests_failed++;
        $display("FAIL bne%0d_cmp op=%0d rv=%b done=%b want 1 0 0", k, alu_op,
                 redirect_valid, done);
      end
      @(negedge clk);
      tests_run++;
      // Not taken: done here. Taken: in TGT, no done yet.
      if ({done, taken} !== {~t_tab[k], 1'b0}) begin
        tests_failed++;
        $display("FAIL bne%0d_c2 done=%b taken=%b want %b 0", k, done, taken, ~t_tab[k]);
      end
      if (t_tab[k]) begin
        @(negedge clk);
        tests_run++;
        if ({redirect_valid, redirect_pc} !== {1'b1, 32'h50}) begin
          tests_failed++;
          $display("FAIL bne%0d_redir rv=%b rpc=%h want 1 50", k, redirect_valid, redirect_pc);
        end
        @(negedge clk);
        tests_run++;
        if ({done, taken, redirect_valid} !== 3'b110) begin
          tests_failed++;
          $display("FAIL bne%0d_done got=%b want=110", k, {done, taken, redirect_valid});
        end
      end
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_blt_family;
    logic [2:0]  f_tab  [3];
    logic [3:0]  op_tab [3];
    logic        t_tab  [3];
    f_tab[0] = 3'b100; op_tab[0] = 4'd2; t_tab[0] = 1'b1;
    f_tab[1] = 3'b110; op_tab[1] = 4'd3; t_tab[1] = 1'b0;
    f_tab[2] = 3'b111; op_tab[2] = 4'd3; t_tab[2] = 1'b1;
    redirect_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      // Target wraps: FFFFFFFC + 8 = 00000004.
      issue(f_tab[k], 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFC, 32'h8);
      @(negedge clk);
      tests_run++;
      if (alu_op !== op_tab[k]) begin
        tests_failed++;
        $display("FAIL cmp%0d_op got=%0d want=%0d", k, alu_op, op_tab[k]);
      end
      @(negedge clk);
      if (t_tab[k]) begin
        @(negedge clk);
        tests_run++;
        if ({redirect_valid, flush, redirect_pc} !== {2'b11, 32'h4}) begin
          tests_failed++;
          $display("FAIL cmp%0d_wrap rv=%b flush=%b rpc=%h want 1 1 00000004", k,
                   redirect_valid, flush, redirect_pc);
        end
        @(negedge clk);
      end
      tests_run++;
      if ({done, taken, illegal} !== {1'b1, t_tab[k], 1'b0}) begin
        tests_failed++;
        $display("FAIL cmp%0d_done got=%b want=%b", k, {done, taken, illegal},
                 {1'b1, t_tab[k], 1'b0});
      end
    end
    redirect_ready = 1'b0;
  endtask

  task automatic test_stall;
    int done_cnt;
    issue(3'b101, 32'h7, 32'h3, 32'h1000, 32'h40);  // BGE 7>=3 taken
    repeat (3) @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      start = (c == 1 || c == 2);  // stray start while busy
      funct3 = 3'b000;
      tests_run++;
      if ({redirect_valid, flush, redirect_pc, ready, done} !== {2'b11, 32'h1040, 2'b00}) begin
        tests_failed++;
        $display("FAIL stall%0d rv=%b flush=%b rpc=%h ready=%b done=%b want 1 1 1040 0 0", c,
                 redirect_valid, flush, redirect_pc, ready, done);
      end
      @(negedge clk);
    end
    start = 1'b0;
    redirect_ready = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      redirect_ready = 1'b0;
      if (done) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 1 || ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_done_once count=%0d ready=%b want 1 1", done_cnt, ready);
    end
  endtask

  task automatic test_illegal_b2b;
    issue(3'b010, 32'h1, 32'h1, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if ({done, illegal, taken, redirect_valid, ready} !== 5'b11001) begin
      tests_failed++;
      $display("FAIL illegal_done got=%b want=11001",
               {done, illegal, taken, redirect_valid, ready});
    end
    issue(3'b001, 32'h9, 32'h9, 32'h0, 32'h0);  // accepted in the done cycle
    @(negedge clk);
    tests_run++;
    if ({alu_op, alu_a, done, illegal, ready} !== {4'd1, 32'h9, 3'b000}) begin
      tests_failed++;
      $display("FAIL b2b_cmp op=%0d a=%h done=%b illegal=%b ready=%b want 1 9 0 0 0",
               alu_op, alu_a, done, illegal, ready);
    end
    @(negedge clk);
    tests_run++;
    if ({done, taken, illegal} !== 3'b100) begin
      tests_failed++;
      $display("FAIL b2b_done got=%b want=100", {done, taken, illegal});
    end
  endtask

  task automatic test_reset_mid;
    int done_cnt;
    issue(3'b000, 32'h0, 32'h0, 32'h200, 32'h10);
    repeat (3) @(negedge clk);
    tests_run++;
    if (redirect_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL rstmid_pre rv=%b want 1", redirect_valid);
    end
    redirect_ready = 1'b1;
    rst = 1'b1;
    #1;
    tests_run++;
    if ({redirect_valid, flush, ready, done} !== 4'b0010) begin
      tests_failed++;
      $display("FAIL rstmid_async got=%b want=0010", {redirect_valid, flush, ready, done});
    end
    @(negedge clk);
    rst = 1'b0;
    redirect_ready = 1'b0;
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done || !ready) done_cnt++;
    end
    tests_run++;
    if (done_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rstmid_no_done bad_cycles=%0d want 0", done_cnt);
    end
  endtask

`ifdef BRANCH_MISALIGN_TRAP_EN
  task automatic test_misalign;
    int rv_cnt;
    rv_cnt = 0;
    redirect_ready = 1'b1;
    issue(3'b000, 32'h3, 32'h3, 32'h100, 32'h2);
    @(negedge clk);
    if (redirect_valid || flush) rv_cnt++;
    @(negedge clk);
    if (redirect_valid || flush) rv_cnt++;
    @(negedge clk);
    if (redirect_valid || flush) rv_cnt++;
    tests_run++;
    if ({done, taken, misalign, illegal} !== 4'b1110 || rv_cnt !== 0) begin
      tests_failed++;
      $display("FAIL misalign got=%b want=1110 redirect_cycles=%0d want 0",
               {done, taken, misalign, illegal}, rv_cnt);
    end
    @(negedge clk);
    redirect_ready = 1'b0;
    tests_run++;
    if ({done, misalign} !== 2'b00) begin
      tests_failed++;
      $display("FAIL misalign_clear done=%b misalign=%b want 0 0", done, misalign);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_beq_taken();
    test_bne();
    test_blt_family();
    test_stall();
    test_illegal_b2b();
`ifdef BRANCH_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
